vending_machine_param: RTL and testbench
========================================

Name: vending_machine_param

Overview:
Parametrised successor to the fixed 3-goods vending controller. It accepts two coin denominations and supports NUM_GOODS selectable goods with per-good prices and per-good stock counters. Additional behaviour: refund, credit saturation with coin rejection, sold-out denial, inactivity auto-refund, and restock. The block sits between the coin/key front-end and the dispense/change actuators.

Parameters:
NUM_GOODS, 3, number of selectable goods (1..7)
CREDIT_W, 4, width of the credit and change values; MAX_CREDIT = 2**CREDIT_W-1
COIN_SMALL, 1, credit value of coin code 2'b01
COIN_LARGE, 5, credit value of coin code 2'b10
PRICE_BASE, 1, price of good 0
PRICE_STEP, 1, price(i) = PRICE_BASE + i*PRICE_STEP; every price must be <= MAX_CREDIT
STOCK_W, 3, width of each stock counter
INIT_STOCK, 4, stock loaded at reset and on restock
TIMEOUT_CYCLES, 16, idle cycles in ACCUM before auto-refund; 0 disables the timeout

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
coin  in  2  00 none, 01 small, 10 large, 11 illegal (ignored, no reject); one coin per cycle while non-zero
keys  in  NUM_GOODS+1  bit0 = refund; bit i+1 = select good i
restock  in  NUM_GOODS  per-good restock strobe
sell  out  NUM_GOODS  one-hot dispense pulse, 1 cycle
change  out  CREDIT_W  change value, valid only while change_valid=1, otherwise 0
change_valid  out  1  1-cycle pulse accompanying a vend or refund
deny  out  1  1-cycle pulse: selection refused (insufficient credit or sold out)
coin_reject  out  1  1-cycle pulse: the coin sampled last cycle was returned
credit  out  CREDIT_W  current registered credit
sold_out  out  NUM_GOODS  bit i = 1 when stock(i)==0 (registered)

Behaviour:
- Reset (async, any state): state=IDLE, credit=0, every stock=INIT_STOCK, timeout counter=0, sell/change/change_valid/deny/coin_reject=0, sold_out=0. Credit held at reset is discarded; no change is output.
- FSM states: IDLE (credit==0), ACCUM (credit>0), DISPENSE (single output cycle).
- Registered outputs: a decision made on inputs sampled at edge N appears on outputs for exactly the cycle following edge N (1-cycle latency).
- Effective credit this cycle: eff = credit + value(coin). If eff > MAX_CREDIT, the coin is rejected (coin_reject=1 next cycle, credit unchanged) and eff = credit.
- Key priority: refund (bit0) beats any select; among selects, the lowest index wins. Lower-priority keys pressed in the same cycle are ignored.
- IDLE/ACCUM, select good i with eff >= price(i) and stock(i) > 0: go to DISPENSE. Next cycle: sell[i]=1, change=eff-price(i) (0 is legal; change_valid still pulses), stock(i)-=1, credit=0.
- Select with eff < price(i), or with stock(i)==0: deny pulse. Credit becomes eff (an accepted coin is kept). No state change other than IDLE->ACCUM if eff > 0.
- Refund with eff > 0: go to DISPENSE, change=eff, sell=0, credit=0. Refund with eff==0: no action, no pulse.
- Coin only: credit=eff; IDLE->ACCUM when eff > 0.
- DISPENSE: lasts one cycle, then IDLE. Keys are ignored. A non-zero legal coin is rejected (coin_reject pulse).
- Timeout: in ACCUM, the counter increments on each cycle with coin==00 and keys==0, and clears on any activity. On reaching TIMEOUT_CYCLES, an auto-refund follows the refund path.
- Restock: restock[i] sets stock(i)=INIT_STOCK in any state. If it coincides with a vend of good i, restock wins for the count (stock = INIT_STOCK) and the vend still completes.
- Stock never wraps: a vend is impossible at 0 by the sold-out rule.
- sold_out is updated in the same cycle as the stock register.

Decomposition:
- Package vending_pkg: state enum (IDLE, ACCUM, DISPENSE); coin code constants COIN_NONE/COIN_SMALL_C/COIN_LARGE_C; function price(idx).
- Sub-module vm_stock_bank: NUM_GOODS stock counters with decrement, restock and sold_out outputs.
- The top level holds the FSM, the credit register and the timeout counter.

Test Plan:
- Defaults; coin=10 for 1 cycle, then keys=0100 (good1, price 2) -> next cycle sell=010, change=3, change_valid=1; credit=0; stock(1)=3.
- coin=01 for 3 cycles, then keys=0010 (good0, price 1) -> sell=001, change=2; state returns to IDLE.
- coin=01 for 2 cycles, then keys=0001 -> sell=000, change=2, change_valid=1. Second case: refund with credit 0 -> no pulses.
- coin=10 three times (credit 15), then one more coin=01 -> coin_reject=1, credit stays 15. keys=1000 (good2, price 3) -> sell=100, change=12.
- Vend good0 4 times -> sold_out[0]=1; the fifth select -> deny=1, credit kept. Then restock=001 -> sold_out[0]=0, stock=4.
- coin=01 once, then 16 idle cycles -> auto-refund change=1. Second case: assert rst during ACCUM with credit 4 -> all outputs 0, credit 0, no change pulse.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared types and helpers for the parametrised vending controller.
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ACCUM    = 2'b01,
    DISPENSE = 2'b10
  } state_t;

  localparam logic [1:0] COIN_NONE    = 2'b00;
  localparam logic [1:0] COIN_SMALL_C = 2'b01;
  localparam logic [1:0] COIN_LARGE_C = 2'b10;

  // Linear price ladder: good 0 costs base, each following good costs step more.
  function automatic int price(input int base, input int step, input int idx);
    return base + idx * step;
  endfunction

endpackage

// File: rtl/vending_machine_param_if.sv
// Front-end / actuator signal bundle of the vending controller.
interface vending_machine_param_if #(
  parameter int NUM_GOODS = 3,
  parameter int CREDIT_W  = 4
) ();

  logic [1:0]           coin;
  logic [NUM_GOODS:0]   keys;
  logic [NUM_GOODS-1:0] restock;
  logic [NUM_GOODS-1:0] sell;
  logic [CREDIT_W-1:0]  change;
  logic                 change_valid;
  logic                 deny;
  logic                 coin_reject;
  logic [CREDIT_W-1:0]  credit;
  logic [NUM_GOODS-1:0] sold_out;

  modport slave (
    input  coin, keys, restock,
    output sell, change, change_valid, deny, coin_reject, credit, sold_out
  );

  modport master (
    output coin, keys, restock,
    input  sell, change, change_valid, deny, coin_reject, credit, sold_out
  );

endinterface

// File: rtl/vm_stock_bank.sv
// Per-good stock counters with vend decrement, restock reload and registered sold-out flags.
module vm_stock_bank #(
  parameter int NUM_GOODS  = 3,
  parameter int STOCK_W    = 3,
  parameter int INIT_STOCK = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_GOODS-1:0] i_dec,
  input  logic [NUM_GOODS-1:0] i_restock,
  output logic [NUM_GOODS-1:0] o_sold_out
);

  logic [STOCK_W-1:0]   r_stock [NUM_GOODS];
  logic [STOCK_W-1:0]   w_stock_nxt [NUM_GOODS];
  logic [NUM_GOODS-1:0] r_sold_out;
  logic [NUM_GOODS-1:0] w_sold_nxt;

  // Next count per good: restock wins over a simultaneous vend; zero never wraps.
  always_comb begin
    for (int i = 0; i < NUM_GOODS; i++) begin
      w_stock_nxt[i] = r_stock[i];
      if (i_restock[i]) begin
        w_stock_nxt[i] = STOCK_W'(INIT_STOCK);
      end else if (i_dec[i] && (r_stock[i] != '0)) begin
        w_stock_nxt[i] = r_stock[i] - STOCK_W'(1);
      end else begin
        w_stock_nxt[i] = r_stock[i];
      end
      w_sold_nxt[i] = (w_stock_nxt[i] == '0);
    end
  end

  // Stock and sold-out flags move together on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_GOODS; i++) begin
        r_stock[i] <= STOCK_W'(INIT_STOCK);
      end
      r_sold_out <= '0;
    end else begin
      for (int i = 0; i < NUM_GOODS; i++) begin
        r_stock[i] <= w_stock_nxt[i];
      end
      r_sold_out <= w_sold_nxt;
    end
  end

  assign o_sold_out = r_sold_out;

endmodule

// File: rtl/vending_machine_param.sv
// Parametrised vending controller: credit accumulation, vend/refund FSM, inactivity timeout.
module vending_machine_param
  import vending_pkg::*;
#(
  parameter int NUM_GOODS      = 3,
  parameter int CREDIT_W       = 4,
  parameter int COIN_SMALL     = 1,
  parameter int COIN_LARGE     = 5,
  parameter int PRICE_BASE     = 1,
  parameter int PRICE_STEP     = 1,
  parameter int STOCK_W        = 3,
  parameter int INIT_STOCK     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic                   clk,
  input logic                   rst,
  vending_machine_param_if.slave bus
);

  localparam int MAX_CREDIT = 2**CREDIT_W - 1;
  // Sum is kept wider than credit so a saturating coin is detectable.
  localparam int SUM_W      = CREDIT_W + 8;
  localparam int TO_W       = $clog2(TIMEOUT_CYCLES + 2);

  state_t               r_state, w_state_nxt;
  logic [CREDIT_W-1:0]  r_credit, w_credit_nxt;
  logic [TO_W-1:0]      r_idle_cnt, w_idle_cnt_nxt;
  logic [NUM_GOODS-1:0] r_sell, w_sell_nxt;
  logic [CREDIT_W-1:0]  r_change, w_change_nxt;
  logic                 r_change_valid, w_change_valid_nxt;
  logic                 r_deny, w_deny_nxt;
  logic                 r_coin_reject, w_coin_reject_nxt;

  logic [SUM_W-1:0]     w_coin_val;
  logic [SUM_W-1:0]     w_sum;
  logic                 w_over;
  logic [SUM_W-1:0]     w_eff;
  logic                 w_sel_hit;
  logic [NUM_GOODS-1:0] w_sel_onehot;
  logic [SUM_W-1:0]     w_sel_price;
  logic                 w_sel_sold;
  logic                 w_idle_cyc;
  logic                 w_timeout;
  logic [NUM_GOODS-1:0] w_sold_out;

  // Coin value decode and saturating effective credit.
  always_comb begin
    case (bus.coin)
      COIN_SMALL_C: w_coin_val = SUM_W'(COIN_SMALL);
      COIN_LARGE_C: w_coin_val = SUM_W'(COIN_LARGE);
      default:      w_coin_val = '0;
    endcase
    w_sum  = SUM_W'(r_credit) + w_coin_val;
    w_over = (w_sum > SUM_W'(MAX_CREDIT));
    if (w_over) begin
      w_eff = SUM_W'(r_credit);
    end else begin
      w_eff = w_sum;
    end
  end

  // Lowest-index select wins; scanning downward lets the last hit stand.
  always_comb begin
    w_sel_hit    = 1'b0;
    w_sel_onehot = '0;
    w_sel_price  = '0;
    w_sel_sold   = 1'b0;
    for (int i = NUM_GOODS - 1; i >= 0; i--) begin
      if (bus.keys[i+1]) begin
        w_sel_hit    = 1'b1;
        w_sel_onehot = '0;
        w_sel_onehot[i] = 1'b1;
        w_sel_price  = SUM_W'(price(PRICE_BASE, PRICE_STEP, i));
        w_sel_sold   = w_sold_out[i];
      end else begin
        w_sel_hit = w_sel_hit;
      end
    end
  end

  assign w_idle_cyc = (bus.coin == COIN_NONE) && (bus.keys == '0);
  assign w_timeout  = (TIMEOUT_CYCLES != 0) && (r_state == ACCUM) && w_idle_cyc &&
                      (r_idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Next-state and next-output decisions.
  always_comb begin
    w_state_nxt        = r_state;
    w_credit_nxt       = r_credit;
    w_idle_cnt_nxt     = '0;
    w_sell_nxt         = '0;
    w_change_nxt       = '0;
    w_change_valid_nxt = 1'b0;
    w_deny_nxt         = 1'b0;
    w_coin_reject_nxt  = 1'b0;
    case (r_state)
      DISPENSE: begin
        w_state_nxt       = IDLE;
        w_credit_nxt      = '0;
        w_coin_reject_nxt = (bus.coin == COIN_SMALL_C) || (bus.coin == COIN_LARGE_C);
      end
      IDLE, ACCUM: begin
        w_coin_reject_nxt = w_over;
        if (bus.keys[0]) begin
          if (w_eff != '0) begin
            w_state_nxt        = DISPENSE;
            w_credit_nxt       = '0;
            w_change_nxt       = CREDIT_W'(w_eff);
            w_change_valid_nxt = 1'b1;
          end else begin
            w_credit_nxt = '0;
          end
        end else if (w_sel_hit) begin
          if ((w_eff >= w_sel_price) && !w_sel_sold) begin
            w_state_nxt        = DISPENSE;
            w_credit_nxt       = '0;
            w_sell_nxt         = w_sel_onehot;
            w_change_nxt       = CREDIT_W'(w_eff - w_sel_price);
            w_change_valid_nxt = 1'b1;
          end else begin
            w_deny_nxt   = 1'b1;
            w_credit_nxt = CREDIT_W'(w_eff);
            w_state_nxt  = (w_eff != '0) ? ACCUM : IDLE;
          end
        end else if (w_timeout) begin
          w_state_nxt        = DISPENSE;
          w_credit_nxt       = '0;
          w_change_nxt       = r_credit;
          w_change_valid_nxt = 1'b1;
        end else begin
          w_credit_nxt = CREDIT_W'(w_eff);
          w_state_nxt  = (w_eff != '0) ? ACCUM : IDLE;
          if ((TIMEOUT_CYCLES != 0) && (r_state == ACCUM) && w_idle_cyc) begin
            w_idle_cnt_nxt = r_idle_cnt + TO_W'(1);
          end else begin
            w_idle_cnt_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_credit_nxt = '0;
      end
    endcase
  end

  // State, credit, timeout counter and output pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_credit       <= '0;
      r_idle_cnt     <= '0;
      r_sell         <= '0;
      r_change       <= '0;
      r_change_valid <= 1'b0;
      r_deny         <= 1'b0;
      r_coin_reject  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_credit       <= w_credit_nxt;
      r_idle_cnt     <= w_idle_cnt_nxt;
      r_sell         <= w_sell_nxt;
      r_change       <= w_change_nxt;
      r_change_valid <= w_change_valid_nxt;
      r_deny         <= w_deny_nxt;
      r_coin_reject  <= w_coin_reject_nxt;
    end
  end

  vm_stock_bank #(
    .NUM_GOODS  (NUM_GOODS),
    .STOCK_W    (STOCK_W),
    .INIT_STOCK (INIT_STOCK)
  ) u_stock (
    .clk        (clk),
    .rst        (rst),
    .i_dec      (w_sell_nxt),
    .i_restock  (bus.restock),
    .o_sold_out (w_sold_out)
  );

  assign bus.sell         = r_sell;
  assign bus.change       = r_change;
  assign bus.change_valid = r_change_valid;
  assign bus.deny         = r_deny;
  assign bus.coin_reject  = r_coin_reject;
  assign bus.credit       = r_credit;
  assign bus.sold_out     = w_sold_out;

endmodule

// File: tb/tb_vending_machine_param.sv
// Directed bench for vending_machine_param with a behavioural credit/stock model.
module tb_vending_machine_param;

  localparam int NG = 3, CW = 4, CS = 1, CL = 5, PB = 1, PS = 1;
  localparam int SW = 3, IS = 4, TO = 16;
  localparam int MAXC = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vending_machine_param_if #(.NUM_GOODS(NG), .CREDIT_W(CW)) vif ();

  vending_machine_param #(
    .NUM_GOODS(NG), .CREDIT_W(CW), .COIN_SMALL(CS), .COIN_LARGE(CL),
    .PRICE_BASE(PB), .PRICE_STEP(PS), .STOCK_W(SW), .INIT_STOCK(IS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  int m_credit, m_idle;
  int m_stock [NG];
  bit m_busy;

  int e_sell, e_change, e_cv, e_deny, e_rej, e_credit, e_sold;
  int p_sell, p_change, p_cv, p_deny, p_rej, p_credit, p_sold;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_credit = 0; m_idle = 0; m_busy = 1'b0;
    for (int i = 0; i < NG; i++) m_stock[i] = IS;
    e_sell = 0; e_change = 0; e_cv = 0; e_deny = 0; e_rej = 0; e_credit = 0; e_sold = 0;
  endtask

  // Spec-level reaction to one sampled input vector; results land in p_*.
  task automatic model_step(input int c, input int k, input int r);
    int v, eff, sel, pr;
    bit idle, accum;
    p_sell = 0; p_change = 0; p_cv = 0; p_deny = 0; p_rej = 0;
    v = (c == 1) ? CS : (c == 2) ? CL : 0;
    idle = (c == 0) && (k == 0);
    if (m_busy) begin
      p_rej = (v != 0) ? 1 : 0;
      m_busy = 1'b0; m_credit = 0; m_idle = 0;
    end else begin
      accum = (m_credit > 0);
      eff = m_credit + v;
      if (eff > MAXC) begin p_rej = 1; eff = m_credit; end
      sel = -1;
      for (int i = NG - 1; i >= 0; i--) if (k[i+1]) sel = i;
      if (accum && idle) m_idle++; else m_idle = 0;
      if (k[0]) begin
        if (eff > 0) begin p_change = eff; p_cv = 1; m_credit = 0; m_busy = 1'b1; end
        else m_credit = 0;
      end else if (sel >= 0) begin
        pr = PB + sel * PS;
        if (eff >= pr && m_stock[sel] > 0) begin
          p_sell = 1 << sel; p_change = eff - pr; p_cv = 1;
          m_stock[sel]--; m_credit = 0; m_busy = 1'b1;
        end else begin
          p_deny = 1; m_credit = eff;
        end
      end else if (TO != 0 && m_idle == TO) begin
        p_change = m_credit; p_cv = 1; m_credit = 0; m_busy = 1'b1;
      end else begin
        m_credit = eff;
      end
    end
    for (int i = 0; i < NG; i++) if (r[i]) m_stock[i] = IS;
    p_credit = m_credit;
    p_sold = 0;
    for (int i = 0; i < NG; i++) if (m_stock[i] == 0) p_sold |= (1 << i);
  endtask

  task automatic cyc(input int c, input int k, input int r);
    @(negedge clk);
    vif.coin    = c[1:0];
    vif.keys    = k[NG:0];
    vif.restock = r[NG-1:0];
    model_step(c, k, r);
    @(posedge clk);
    #1;
    e_sell = p_sell; e_change = p_change; e_cv = p_cv; e_deny = p_deny;
    e_rej = p_rej; e_credit = p_credit; e_sold = p_sold;
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("sell",         int'(vif.sell),         e_sell);
      check("change",       int'(vif.change),       e_change);
      check("change_valid", int'(vif.change_valid), e_cv);
      check("deny",         int'(vif.deny),         e_deny);
      check("coin_reject",  int'(vif.coin_reject),  e_rej);
      check("credit",       int'(vif.credit),       e_credit);
      check("sold_out",     int'(vif.sold_out),     e_sold);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    vif.coin = 2'b00; vif.keys = '0; vif.restock = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_credit", int'(vif.credit), 0);
    check("rst_cv",     int'(vif.change_valid), 0);
    #2 rst = 1'b0;
    chk_en = 1'b1;

    // Large coin then good1 (price 2): change 3.
    cyc(2, 0, 0);
    cyc(0, 4'b0100, 0);
    check("t1_sell", int'(vif.sell), 2);
    check("t1_change", int'(vif.change), 3);
    check("t1_cv", int'(vif.change_valid), 1);
    cyc(0, 0, 0);
    check("t1_credit", int'(vif.credit), 0);

    // Three small coins, good0 (price 1): change 2.
    repeat (3) cyc(1, 0, 0);
    cyc(0, 4'b0010, 0);
    check("t2_sell", int'(vif.sell), 1);
    check("t2_change", int'(vif.change), 2);
    cyc(0, 0, 0);

    // Refund with credit 2, then refund with no credit.
    repeat (2) cyc(1, 0, 0);
    cyc(0, 4'b0001, 0);
    check("t3_sell", int'(vif.sell), 0);
    check("t3_change", int'(vif.change), 2);
    check("t3_cv", int'(vif.change_valid), 1);
    cyc(0, 0, 0);
    cyc(0, 4'b0001, 0);
    check("t3_empty_cv", int'(vif.change_valid), 0);

    // Saturation: 15 credit, small coin rejected, good2 (price 3) change 12.
    repeat (3) cyc(2, 0, 0);
    check("t4_credit15", int'(vif.credit), 15);
    cyc(1, 0, 0);
    check("t4_reject", int'(vif.coin_reject), 1);
    check("t4_credit_held", int'(vif.credit), 15);
    cyc(0, 4'b1000, 0);
    check("t4_sell", int'(vif.sell), 4);
    check("t4_change", int'(vif.change), 12);
    cyc(0, 0, 0);

    // Refund beats selects; coin during dispense is rejected; lowest select wins.
    cyc(2, 0, 0);
    cyc(0, 4'b0111, 0);
    check("t5_refund_sell", int'(vif.sell), 0);
    check("t5_refund_change", int'(vif.change), 5);
    cyc(1, 0, 0);
    check("t5_disp_reject", int'(vif.coin_reject), 1);
    cyc(2, 0, 0);
    cyc(0, 4'b1100, 0);
    check("t5_prio_sell", int'(vif.sell), 2);
    cyc(0, 0, 0);

    // Illegal coin code is ignored without reject.
    cyc(3, 0, 0);
    check("t6_illegal_credit", int'(vif.credit), 0);
    check("t6_illegal_rej", int'(vif.coin_reject), 0);

    // Restock coinciding with a vend of the same good.
    cyc(2, 0, 0);
    cyc(0, 4'b0100, 3'b010);
    check("t7_sell", int'(vif.sell), 2);
    cyc(0, 0, 0);

    // Drain good0 from full stock, deny when sold out, then restock.
    cyc(0, 0, 3'b001);
    for (int n = 0; n < 4; n++) begin
      cyc(1, 0, 0);
      cyc(0, 4'b0010, 0);
      cyc(0, 0, 0);
    end
    check("t8_sold_out", int'(vif.sold_out), 1);
    cyc(1, 0, 0);
    cyc(0, 4'b0010, 0);
    check("t8_deny", int'(vif.deny), 1);
    check("t8_credit_kept", int'(vif.credit), 1);
    cyc(0, 0, 3'b001);
    check("t8_restocked", int'(vif.sold_out), 0);
    cyc(0, 4'b0001, 0);
    check("t8_refund", int'(vif.change), 1);
    cyc(0, 0, 0);

    // Inactivity auto-refund after 16 idle cycles.
    cyc(1, 0, 0);
    repeat (15) cyc(0, 0, 0);
    check("t9_no_early_refund", int'(vif.change_valid), 0);
    cyc(0, 0, 0);
    check("t9_auto_cv", int'(vif.change_valid), 1);
    check("t9_auto_change", int'(vif.change), 1);
    cyc(0, 0, 0);

    // Asynchronous reset while holding credit 4.
    repeat (4) cyc(1, 0, 0);
    check("t10_credit4", int'(vif.credit), 4);
    @(negedge clk);
    chk_en = 1'b0;
    vif.coin = 2'b00; vif.keys = '0; vif.restock = '0;
    #2 rst = 1'b1;
    #1;
    check("t10_rst_credit", int'(vif.credit), 0);
    check("t10_rst_cv", int'(vif.change_valid), 0);
    check("t10_rst_sell", int'(vif.sell), 0);
    model_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    chk_en = 1'b1;
    cyc(0, 0, 0);
    check("t10_post_cv", int'(vif.change_valid), 0);

    // Normal operation after reset: good2 with 5 credit.
    cyc(2, 0, 0);
    cyc(0, 4'b1000, 0);
    check("t11_change", int'(vif.change), 2);
    cyc(0, 0, 0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
